// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive engine.
//   state_e      receiver FSM states
//   PARITY_*     parity mode encodings for the PARITY_MODE parameter
//   parity_bit() expected parity bit for a data word in a given mode
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DELIVER,
        BREAK
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest supported word; narrower words are zero-extended, which
    // leaves their XOR unchanged.
    localparam int MAX_DATA_BITS = 9;

    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int                       mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: synchroniser, sample-tick divider,
// per-bit tick counter and 3-sample majority vote.
//   trueclk       system clock
//   reset         synchronous, active-low
//   rx_i          raw asynchronous serial line
//   restart_i     realign divider and tick counter (IDLE-to-START)
//   rx_s_o        synchronised line
//   bit_strobe_o  1-cycle pulse: bit_value_o holds a bit decision
//   bit_value_o   majority of the last three samples
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic trueclk,
    input  logic reset,
    input  logic rx_i,
    input  logic restart_i,
    output logic rx_s_o,
    output logic bit_strobe_o,
    output logic bit_value_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TCNT_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 + 1);

    logic [1:0]        sync_q;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [TCNT_W-1:0] tcnt_q,   tcnt_d;
    logic [2:0]        win_q,    win_d;
    logic              strobe_q, strobe_d;
    logic              tick;

    assign rx_s_o       = sync_q[1];
    assign tick         = (div_q == DIV_LAST);
    assign bit_strobe_o = strobe_q;
    assign bit_value_o  = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);

    always_comb begin
        // NOTE: every next-state value gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        div_d  = div_q;
        tcnt_d = tcnt_q;
        win_d  = win_q;
        if (restart_i) begin
            div_d  = '0;
            tcnt_d = '0;
        end else if (tick) begin
            div_d  = '0;
            tcnt_d = (tcnt_q == TCNT_LAST) ? '0 : tcnt_q + 1'b1;
        end else begin
            div_d  = div_q + 1'b1;
        end
        if (tick) begin
            win_d = {win_q[1:0], rx_s_o};
        end
        // The strobe is registered so the window already holds the
        // decision-tick sample; a restart must not leak a stale strobe
        // into the START state.
        strobe_d = tick && (tcnt_q == TCNT_MID) && !restart_i;
    end

    always_ff @(posedge trueclk) begin
        // NOTE: reset is synchronous, so it is just the first branch of the clocked block; the synchroniser and window preset to 1 so an idle line never looks like a start bit.
        if (!reset) begin
            sync_q   <= 2'b11;
            div_q    <= '0;
            tcnt_q   <= '0;
            win_q    <= 3'b111;
            strobe_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            sync_q   <= {sync_q[0], rx_i};
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            win_q    <= win_d;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receive engine with parity, stop-bit checking and a
// valid/ready output handshake.
//   trueclk      system clock
//   reset        synchronous, active-low
//   rx_in        asynchronous serial line, idles high
//   data_out     last received word
//   data_valid   data_out / parity_err / frame_err are valid
//   data_ready   consumer accepts the word this cycle
//   parity_err   parity mismatch for the word in data_out
//   frame_err    a stop bit of the word in data_out sampled 0
//   overrun_err  1-cycle pulse: new word overwrote an unconsumed word
//   busy         high in every state except IDLE
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int CLK_DIV     = 4,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 trueclk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_e               state_q,      state_d;
    logic [IDX_W-1:0]     bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 parity_bad_q, parity_bad_d;
    logic                 frame_bad_q,  frame_bad_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 valid_q,      valid_d;
    logic                 perr_q,       perr_d;
    logic                 ferr_q,       ferr_d;
    logic                 ovr_q,        ovr_d;

    logic rx_s, bit_strobe, bit_value;
    logic restart, deliver;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CLK_DIV    (CLK_DIV)
    ) u_sampler (
        .trueclk      (trueclk),
        .reset        (reset),
        .rx_i         (rx_in),
        .restart_i    (restart),
        .rx_s_o       (rx_s),
        .bit_strobe_o (bit_strobe),
        .bit_value_o  (bit_value)
    );

    // State register.
    always_ff @(posedge trueclk) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_bad_q <= 1'b0;
            frame_bad_q  <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            parity_bad_q <= parity_bad_d;
            frame_bad_q  <= frame_bad_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            ovr_q        <= ovr_d;
        end
    end

    // Next-state logic: frame FSM and output handshake.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_bad_d = parity_bad_q;
        frame_bad_d  = frame_bad_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d      = START;
                    parity_bad_d = 1'b0;
                    frame_bad_d  = 1'b0;
                end
            end
            START: begin
                if (bit_strobe) begin
                    // A start bit that reads back high was a glitch.
                    state_d   = bit_value ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
                    shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_DATA) begin
                        state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    parity_bad_d = (bit_value != parity_bit(MAX_DATA_BITS'(shift_q), PARITY_MODE));
                    state_d      = STOP;
                    bit_idx_d    = '0;
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    if (!bit_value) begin
                        frame_bad_d = 1'b1;
                    end
                    if (bit_idx_q == LAST_STOP) begin
                        state_d = DELIVER;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            DELIVER: begin
                // A low line after a bad stop bit is a break; wait it out
                // rather than treating it as the next start bit.
                state_d = (frame_bad_q && !rx_s) ? BREAK : IDLE;
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        data_out_d = data_out_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = 1'b0;
        if (deliver) begin
            // A new word always wins; losing an unconsumed one is flagged.
            data_out_d = shift_q;
            perr_d     = parity_bad_q;
            ferr_d     = frame_bad_q;
            valid_d    = 1'b1;
            ovr_d      = valid_q && !data_ready;
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    // Output / control decode from the current state.
    always_comb begin
        busy    = (state_q != IDLE);
        restart = (state_q == IDLE) && !rx_s;
        deliver = (state_q == DELIVER);
    end

    assign data_out    = data_out_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule
